// File: rtl/fan_pkg.sv
// fan_pkg: shared definitions for the fan speed controller.
//   - level encoding (LVL_OFF..LVL_HIGH)
//   - ramp FSM state encoding
//   - default thresholds/speeds, also used by the smart-home top level
//   - sat_sub: saturating 8-bit subtract, used for hysteresis thresholds
package fan_pkg;

    localparam logic [1:0] LVL_OFF  = 2'd0;
    localparam logic [1:0] LVL_LOW  = 2'd1;
    localparam logic [1:0] LVL_MED  = 2'd2;
    localparam logic [1:0] LVL_HIGH = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StKick = 2'd1,
        StRun  = 2'd2
    } ramp_state_e;

    localparam logic [7:0] DEF_T_LOW    = 8'd25;
    localparam logic [7:0] DEF_T_MED    = 8'd30;
    localparam logic [7:0] DEF_T_HIGH   = 8'd35;
    localparam logic [7:0] DEF_HYST     = 8'd2;
    localparam logic [7:0] DEF_SPD_LOW  = 8'd64;
    localparam logic [7:0] DEF_SPD_MED  = 8'd128;
    localparam logic [7:0] DEF_SPD_HIGH = 8'd255;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/fan_level_fsm.sv
// fan_level_fsm: hysteresis level register.
// Ports:
//   clk, arst       - clock, synchronous active-high reset
//   temp_valid      - one-cycle strobe qualifying temp
//   temp[7:0]       - unsigned temperature in degC
//   level[1:0]      - current demand level (LVL_OFF..LVL_HIGH), registered
// Rising temperature uses the plain thresholds; falling temperature uses the
// thresholds lowered by HYST, so the level only drops once clearly below.
module fan_level_fsm
    import fan_pkg::*;
#(
    parameter logic [7:0] T_LOW  = DEF_T_LOW,
    parameter logic [7:0] T_MED  = DEF_T_MED,
    parameter logic [7:0] T_HIGH = DEF_T_HIGH,
    parameter logic [7:0] HYST   = DEF_HYST
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       temp_valid,
    input  logic [7:0] temp,
    output logic [1:0] level
);

    localparam logic [7:0] T_LOW_DN  = sat_sub(T_LOW, HYST);
    localparam logic [7:0] T_MED_DN  = sat_sub(T_MED, HYST);
    localparam logic [7:0] T_HIGH_DN = sat_sub(T_HIGH, HYST);

    logic [1:0] level_q;
    logic [1:0] up_lvl;
    logic [1:0] dn_lvl;

    always_comb begin
        up_lvl = LVL_OFF;
        if (temp >= T_HIGH)     up_lvl = LVL_HIGH;
        else if (temp >= T_MED) up_lvl = LVL_MED;
        else if (temp >= T_LOW) up_lvl = LVL_LOW;

        dn_lvl = LVL_OFF;
        if (temp >= T_HIGH_DN)     dn_lvl = LVL_HIGH;
        else if (temp >= T_MED_DN) dn_lvl = LVL_MED;
        else if (temp >= T_LOW_DN) dn_lvl = LVL_LOW;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            level_q <= LVL_OFF;
        end else if (temp_valid) begin
            if (up_lvl > level_q) begin
                level_q <= up_lvl;
            end else if (dn_lvl < level_q) begin
                level_q <= dn_lvl;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: temperature-driven fan demand with rate-limited ramp and
// full-power kick-start from standstill. Drives FanSpeed.speed.
// Ports:
//   clk, arst       - clock, synchronous active-high reset
//   temp_valid      - one-cycle strobe qualifying temp
//   temp[7:0]       - unsigned temperature in degC
//   man_en          - manual override enable (level-sensitive)
//   man_speed[7:0]  - override speed
//   speed[7:0]      - PWM speed command (registered)
//   level[1:0]      - demand level 0=OFF..3=HIGH (registered)
//   kick            - high while spinning up at 255 (registered)
//   at_target       - speed equals target and not kicking (registered)
module fan_speed_ctrl
    import fan_pkg::*;
#(
    parameter int unsigned RAMP_DIV    = 256,
    parameter int unsigned STEP        = 4,
    parameter int unsigned KICK_CYCLES = 1024,
    parameter logic [7:0]  T_LOW       = DEF_T_LOW,
    parameter logic [7:0]  T_MED       = DEF_T_MED,
    parameter logic [7:0]  T_HIGH      = DEF_T_HIGH,
    parameter logic [7:0]  HYST        = DEF_HYST,
    parameter logic [7:0]  SPD_LOW     = DEF_SPD_LOW,
    parameter logic [7:0]  SPD_MED     = DEF_SPD_MED,
    parameter logic [7:0]  SPD_HIGH    = DEF_SPD_HIGH
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       temp_valid,
    input  logic [7:0] temp,
    input  logic       man_en,
    input  logic [7:0] man_speed,
    output logic [7:0] speed,
    output logic [1:0] level,
    output logic       kick,
    output logic       at_target
);

    localparam int unsigned PW = $clog2(RAMP_DIV);
    localparam int unsigned KW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [KW-1:0] KICK_LAST  = KW'(KICK_CYCLES - 1);
    localparam logic [7:0]    STEP_B     = 8'(STEP);

    logic [1:0]    lvl;
    logic [7:0]    lvl_speed;
    logic [7:0]    target_q, target_d;
    ramp_state_e   state_q, state_d;
    logic [7:0]    speed_q, speed_d;
    logic          kick_q, kick_d;
    logic          at_target_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic          going_up;
    logic [7:0]    diff, delta, stepped;

    fan_level_fsm #(
        .T_LOW  (T_LOW),
        .T_MED  (T_MED),
        .T_HIGH (T_HIGH),
        .HYST   (HYST)
    ) u_level (
        .clk        (clk),
        .arst       (arst),
        .temp_valid (temp_valid),
        .temp       (temp),
        .level      (lvl)
    );

    always_comb begin
        lvl_speed = 8'd0;
        unique case (lvl)
            LVL_OFF:  lvl_speed = 8'd0;
            LVL_LOW:  lvl_speed = SPD_LOW;
            LVL_MED:  lvl_speed = SPD_MED;
            LVL_HIGH: lvl_speed = SPD_HIGH;
            default:  lvl_speed = 8'd0;
        endcase
        target_d = man_en ? man_speed : lvl_speed;
    end

    // Clamped step toward target: never overshoots, never wraps.
    always_comb begin
        going_up = target_q > speed_q;
        diff     = going_up ? (target_q - speed_q) : (speed_q - target_q);
        delta    = (diff < STEP_B) ? diff : STEP_B;
        stepped  = going_up ? (speed_q + delta) : (speed_q - delta);
    end

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        kick_d  = kick_q;
        presc_d = presc_q;
        kcnt_d  = kcnt_q;
        unique case (state_q)
            StIdle: begin
                if (target_q != 8'd0) begin
                    state_d = StKick;
                    speed_d = 8'd255;
                    kick_d  = 1'b1;
                    kcnt_d  = '0;
                end
            end
            StKick: begin
                if (target_q == 8'd0) begin
                    state_d = StIdle;
                    speed_d = 8'd0;
                    kick_d  = 1'b0;
                end else if (kcnt_q == KICK_LAST) begin
                    state_d = StRun;
                    speed_d = target_q;
                    kick_d  = 1'b0;
                    presc_d = '0;
                end else begin
                    kcnt_d = kcnt_q + 1'b1;
                end
            end
            StRun: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    speed_d = stepped;
                    if (stepped == 8'd0) state_d = StIdle;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                speed_d = 8'd0;
                kick_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            target_q    <= 8'd0;
            state_q     <= StIdle;
            speed_q     <= 8'd0;
            kick_q      <= 1'b0;
            at_target_q <= 1'b1;
            presc_q     <= '0;
            kcnt_q      <= '0;
        end else begin
            target_q    <= target_d;
            state_q     <= state_d;
            speed_q     <= speed_d;
            kick_q      <= kick_d;
            // Built from next-state values so it matches speed/target as registered.
            at_target_q <= (speed_d == target_d) && !kick_d;
            presc_q     <= presc_d;
            kcnt_q      <= kcnt_d;
        end
    end

    assign speed     = speed_q;
    assign level     = lvl;
    assign kick      = kick_q;
    assign at_target = at_target_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed testbench for fan_speed_ctrl with RAMP_DIV=4, KICK_CYCLES=8, STEP=16.
module tb_fan_speed_ctrl;

    localparam int unsigned RD = 4;
    localparam int unsigned KC = 8;
    localparam int unsigned ST = 16;

    logic       clk = 1'b0;
    logic       arst;
    logic       temp_valid;
    logic [7:0] temp;
    logic       man_en;
    logic [7:0] man_speed;
    logic [7:0] speed;
    logic [1:0] level;
    logic       kick;
    logic       at_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fan_speed_ctrl #(
        .RAMP_DIV    (RD),
        .STEP        (ST),
        .KICK_CYCLES (KC)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .temp_valid (temp_valid),
        .temp       (temp),
        .man_en     (man_en),
        .man_speed  (man_speed),
        .speed      (speed),
        .level      (level),
        .kick       (kick),
        .at_target  (at_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe(input int t);
        temp       = 8'(t);
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
    endtask

    function automatic int step_toward(input int cur, input int to);
        int diff;
        int d;
        diff = (to > cur) ? (to - cur) : (cur - to);
        d    = (diff < int'(ST)) ? diff : int'(ST);
        return (to > cur) ? (cur + d) : (cur - d);
    endfunction

    // Waits for the first step, then expects one step exactly every RD cycles.
    task automatic expect_ramp(input int from, input int to, input string tag);
        int cur;
        int nxt;
        int n;
        cur = from;
        n   = 0;
        while (speed == 8'(cur) && n < 3 * int'(RD) + 8) begin
            tick();
            n++;
        end
        while (cur != to) begin
            nxt = step_toward(cur, to);
            check({tag, " step"}, speed, nxt);
            cur = nxt;
            if (cur != to) begin
                repeat (RD - 1) begin
                    tick();
                    check({tag, " hold"}, speed, cur);
                end
                tick();
            end
        end
    endtask

    task automatic wait_kick_done(input string tag);
        int n;
        n = 0;
        while (kick === 1'b1 && n < int'(KC) + 4) begin
            tick();
            n++;
        end
        check({tag, " kick end"}, kick, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst       = 1'b1;
        temp_valid = 1'b1;   // must be ignored while in reset
        temp       = 8'd40;
        man_en     = 1'b0;
        man_speed  = 8'd0;
        repeat (3) tick();
        check("rst speed", speed, 0);
        check("rst level", level, 0);
        check("rst kick", kick, 0);
        check("rst at_target", at_target, 1);
        temp_valid = 1'b0;
        arst       = 1'b0;
        tick();
        check("post rst level", level, 0);

        // Cold start
        strobe(31);
        check("cold level", level, 2);
        tick();
        check("cold no kick yet", kick, 0);
        tick();
        check("cold kick", kick, 1);
        check("cold speed 255", speed, 255);
        check("cold at_target", at_target, 0);
        repeat (KC - 1) begin
            tick();
            check("cold kick hold", kick, 1);
            check("cold speed hold", speed, 255);
        end
        tick();
        check("cold run speed", speed, 128);
        check("cold run kick", kick, 0);
        check("cold run at_target", at_target, 1);

        // Hysteresis
        strobe(29);
        check("hyst 29 level", level, 2);
        repeat (6) tick();
        check("hyst 29 speed", speed, 128);
        strobe(27);
        check("hyst 27 level", level, 1);
        expect_ramp(128, 64, "hyst");
        check("hyst at_target", at_target, 1);

        // Down to off, then multi-level jump and clamp to zero
        strobe(0);
        check("off level", level, 0);
        expect_ramp(64, 0, "off");
        repeat (2 * RD) tick();
        check("off speed", speed, 0);
        check("off kick", kick, 0);
        strobe(40);
        check("jump level", level, 3);
        tick();
        check("jump no kick yet", kick, 0);
        tick();
        check("jump kick", kick, 1);
        check("jump speed", speed, 255);
        wait_kick_done("jump");
        check("jump run speed", speed, 255);
        strobe(0);
        check("clamp level", level, 0);
        expect_ramp(255, 0, "clamp");
        repeat (2 * RD) tick();
        check("clamp idle speed", speed, 0);
        check("clamp idle kick", kick, 0);
        check("clamp at_target", at_target, 1);

        // Kick abort
        strobe(26);
        check("abort level1", level, 1);
        tick();
        tick();
        check("abort kick on", kick, 1);
        tick();
        tick();
        strobe(10);
        check("abort level0", level, 0);
        check("abort kick still", kick, 1);
        tick();
        check("abort speed 255", speed, 255);
        tick();
        check("abort speed 0", speed, 0);
        check("abort kick off", kick, 0);
        repeat (3) tick();
        check("abort stays 0", speed, 0);

        // Manual override
        strobe(26);
        tick();
        tick();
        check("ovr kick", kick, 1);
        wait_kick_done("ovr");
        check("ovr base speed", speed, 64);
        man_en    = 1'b1;
        man_speed = 8'd200;
        expect_ramp(64, 200, "ovr up");
        check("ovr up final", speed, 200);
        check("ovr up at_target", at_target, 1);
        man_en = 1'b0;
        expect_ramp(200, 64, "ovr dn");
        check("ovr dn at_target", at_target, 1);

        // Reset in the middle of a ramp
        man_en    = 1'b1;
        man_speed = 8'd100;
        expect_ramp(64, 100, "pre rst");
        man_speed = 8'd0;
        tick();
        check("mid ramp speed", speed, 100);
        arst   = 1'b1;
        man_en = 1'b0;
        tick();
        check("rst2 speed", speed, 0);
        check("rst2 level", level, 0);
        check("rst2 kick", kick, 0);
        check("rst2 at_target", at_target, 1);
        tick();
        tick();
        arst = 1'b0;
        tick();
        check("rst2 after speed", speed, 0);
        check("rst2 after kick", kick, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
